// File: rtl/timekeeper_timer.sv
// Cycle timer: pulses tick every Wait+1 clocks, or in one-shot mode raises tick
// once after Wait clocks and holds it until the next reset.
module timekeeper_timer #(
    parameter int Wait      = 2,
    parameter int TimerBits = 2,
    parameter int OneShot   = 0
) (
    input  logic                 clk,
    input  logic                 res,
    output logic                 tick,
    output logic [TimerBits-1:0] count
);

    if (TimerBits < 1 || Wait < 0 ||
        longint'(Wait) >= (longint'(1) << TimerBits)) begin : g_bad_wait
        $fatal(1, "timekeeper_timer: Wait must fit in TimerBits bits and TimerBits must be >= 1");
    end

    if (OneShot != 0 && OneShot != 1) begin : g_bad_mode
        $fatal(1, "timekeeper_timer: OneShot must be 0 or 1");
    end

    localparam logic [TimerBits-1:0] Terminal = TimerBits'(Wait);
    localparam logic [TimerBits-1:0] One      = TimerBits'(1);

    logic [TimerBits-1:0] cnt;
    logic                 at_wait;

    assign at_wait = (cnt == Terminal);

    // One-shot mode parks on the terminal value so tick stays asserted.
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt <= '0;
        end else if (at_wait) begin
            cnt <= (OneShot == 1) ? cnt : '0;
        end else begin
            cnt <= cnt + One;
        end
    end

    // Gating with res drops tick in the same cycle reset is asserted.
    assign tick  = res & at_wait;
    assign count = cnt;

endmodule

// File: tb/tb_timekeeper_timer.sv
// Scoreboard bench for timekeeper_timer: four parameterisations driven with random
// reset pulses and checked against an edge-counting reference model.
module tb_timekeeper_timer;

    localparam int NDut   = 4;
    localparam int Cycles = 400;

    logic       clk;
    logic [3:0] res;
    logic [3:0] tick;
    logic [1:0] count_periodic;
    logic [1:0] count_oneshot;
    logic [0:0] count_zero;
    logic [1:0] count_max;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit              post;
        logic [3:0][1:0] cnt;
        logic [3:0]      tck;
    } exp_t;

    exp_t sb[$];
    int   edges[NDut];
    int   hold[NDut];

    timekeeper_timer #(.Wait(2), .TimerBits(2), .OneShot(0)) u_periodic (
        .clk(clk), .res(res[0]), .tick(tick[0]), .count(count_periodic));
    timekeeper_timer #(.Wait(2), .TimerBits(2), .OneShot(1)) u_oneshot (
        .clk(clk), .res(res[1]), .tick(tick[1]), .count(count_oneshot));
    timekeeper_timer #(.Wait(0), .TimerBits(1), .OneShot(0)) u_zero (
        .clk(clk), .res(res[2]), .tick(tick[2]), .count(count_zero));
    timekeeper_timer #(.Wait(3), .TimerBits(2), .OneShot(0)) u_max (
        .clk(clk), .res(res[3]), .tick(tick[3]), .count(count_max));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(int i);
        case (i)
            0: return 2;
            1: return 2;
            2: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit oneshot_of(int i);
        return (i == 1);
    endfunction

    // Reference: the count is just a function of edges seen since reset release.
    function automatic int model_count(int i, int n);
        int w;
        w = wait_of(i);
        if (oneshot_of(i)) return (n < w) ? n : w;
        return n % (w + 1);
    endfunction

    function automatic int dut_count(int i);
        case (i)
            0: return int'(count_periodic);
            1: return int'(count_oneshot);
            2: return int'(count_zero);
            default: return int'(count_max);
        endcase
    endfunction

    function automatic exp_t build_expect(bit post);
        exp_t e;
        int   c;
        e.post = post;
        for (int i = 0; i < NDut; i++) begin
            c         = model_count(i, edges[i]);
            e.cnt[i]  = 2'(c);
            e.tck[i]  = res[i] && (c == wait_of(i));
        end
        return e;
    endfunction

    task automatic apply_stimulus(int cycle);
        @(negedge clk);
        for (int i = 0; i < NDut; i++) begin
            if (hold[i] > 0) begin
                res[i]  = 1'b0;
                hold[i] = hold[i] - 1;
            end else if (cycle >= 30 && $urandom_range(0, 11) == 0) begin
                res[i]  = 1'b0;
                hold[i] = int'($urandom_range(0, 3));
            end else begin
                res[i] = 1'b1;
            end
        end
        // Before the edge: state unchanged, only the reset gating on tick applies.
        sb.push_back(build_expect(1'b0));
        for (int i = 0; i < NDut; i++)
            edges[i] = res[i] ? edges[i] + 1 : 0;
        sb.push_back(build_expect(1'b1));
    endtask

    task automatic check_output(string name, int actual, int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic compare_entry(bit post, int cycle);
        exp_t  e;
        string phase;
        phase = post ? "after-edge" : "pre-edge";
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty cycle %0d %s: got 0 entries expected 1", cycle, phase);
            return;
        end
        e = sb.pop_front();
        check_output($sformatf("phase_order cycle %0d", cycle), int'(e.post), int'(post));
        for (int i = 0; i < NDut; i++) begin
            check_output($sformatf("dut%0d count cycle %0d %s", i, cycle, phase),
                         dut_count(i), int'(e.cnt[i]));
            check_output($sformatf("dut%0d tick cycle %0d %s", i, cycle, phase),
                         int'(tick[i]), int'(e.tck[i]));
        end
    endtask

    initial begin
        res = 4'b0000;
        for (int i = 0; i < NDut; i++) begin
            edges[i] = 0;
            hold[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDut; i++) begin
            check_output($sformatf("reset dut%0d count", i), dut_count(i), 0);
            check_output($sformatf("reset dut%0d tick", i), int'(tick[i]), 0);
        end

        fork
            begin
                for (int k = 0; k < Cycles; k++) apply_stimulus(k);
            end
            begin
                for (int m = 0; m < Cycles; m++) begin
                    @(negedge clk);
                    #1;
                    compare_entry(1'b0, m);
                    @(posedge clk);
                    #2;
                    compare_entry(1'b1, m);
                end
            end
        join

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
